// File: rtl/pipe_stage_skid_pkg.sv
// Shared defines for the pipeline-register slice: datapath width, write-back
// select encoding and the skid-stage state encoding.
package pipe_stage_skid_pkg;

   localparam int DATA_WIDTH        = 32;
   localparam int CTRL_W_DEFAULT    = 8;
   localparam int PAYLOAD_W_DEFAULT = 4 * DATA_WIDTH;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2,
      WB_IMM = 2'd3
   } wb_sel_e;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } skid_state_e;

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// One ctrl+data holding register; clearing the ctrl bundle turns the held
// entry into a bubble without disturbing the payload.
module pipe_slot
   import pipe_stage_skid_pkg::*;
#(
   parameter int CTRL_W = CTRL_W_DEFAULT,
   parameter int DATA_W = PAYLOAD_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              clr_ctrl_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o
);

   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [DATA_W-1:0] data_q, data_d;

   // Next-value selection: clear beats load for ctrl, data only follows load.
   always_comb begin
      ctrl_d = ctrl_q;
      data_d = data_q;
      if (clr_ctrl_i) begin
         ctrl_d = {CTRL_W{1'b0}};
      end else if (load_i) begin
         ctrl_d = ctrl_i;
      end else begin
         ctrl_d = ctrl_q;
      end
      if (load_i) begin
         data_d = data_i;
      end else begin
         data_d = data_q;
      end
   end

   // Slot storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q <= {CTRL_W{1'b0}};
         data_q <= {DATA_W{1'b0}};
      end else begin
         ctrl_q <= ctrl_d;
         data_q <= data_d;
      end
   end

   assign ctrl_o = ctrl_q;
   assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline register: full throughput with up_ready_o decoupled
// from dn_ready_i; the main entry always drives the downstream side.
module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int PAYLOAD_W = PAYLOAD_W_DEFAULT,
   parameter int CTRL_W    = CTRL_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush_i,
   input  logic                 up_valid_i,
   output logic                 up_ready_o,
   input  logic [CTRL_W-1:0]    up_ctrl_i,
   input  logic [PAYLOAD_W-1:0] up_data_i,
   output logic                 dn_valid_o,
   input  logic                 dn_ready_i,
   output logic [CTRL_W-1:0]    dn_ctrl_o,
   output logic [PAYLOAD_W-1:0] dn_data_o,
   output logic [1:0]           occupancy_o
);

   skid_state_e state_q, state_d;
   logic        up_ready_q, up_ready_d;
   logic        dn_valid_q, dn_valid_d;
   logic [1:0]  occ_q, occ_d;

   logic up_xfer_s, dn_xfer_s;
   logic main_load_s, main_clr_s, main_from_skid_s;
   logic skid_load_s, skid_clr_s;

   logic [CTRL_W-1:0]    main_ctrl_s, skid_ctrl_s, main_ctrl_in_s;
   logic [PAYLOAD_W-1:0] main_data_s, skid_data_s, main_data_in_s;

   assign up_xfer_s = up_valid_i & up_ready_q;
   assign dn_xfer_s = dn_valid_q & dn_ready_i;

   // Transfer sequencing; main ctrl is cleared whenever the stage empties so
   // the downstream ctrl is a bubble without any output masking.
   always_comb begin
      state_d          = state_q;
      main_load_s      = 1'b0;
      main_clr_s       = 1'b0;
      main_from_skid_s = 1'b0;
      skid_load_s      = 1'b0;
      skid_clr_s       = 1'b0;
      if (flush_i) begin
         state_d    = EMPTY;
         main_clr_s = 1'b1;
         skid_clr_s = 1'b1;
      end else begin
         case (state_q)
            EMPTY: begin
               if (up_xfer_s) begin
                  main_load_s = 1'b1;
                  state_d     = FULL;
               end else begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (up_xfer_s && dn_xfer_s) begin
                  main_load_s = 1'b1;
                  state_d     = FULL;
               end else if (dn_xfer_s) begin
                  main_clr_s = 1'b1;
                  state_d    = EMPTY;
               end else if (up_xfer_s) begin
                  skid_load_s = 1'b1;
                  state_d     = SKID;
               end else begin
                  state_d = FULL;
               end
            end
            SKID: begin
               if (dn_xfer_s) begin
                  main_load_s      = 1'b1;
                  main_from_skid_s = 1'b1;
                  skid_clr_s       = 1'b1;
                  state_d          = FULL;
               end else begin
                  state_d = SKID;
               end
            end
            default: begin
               main_clr_s = 1'b1;
               skid_clr_s = 1'b1;
               state_d    = EMPTY;
            end
         endcase
      end
   end

   // Status outputs are registered images of the next state.
   always_comb begin
      up_ready_d = 1'b1;
      dn_valid_d = 1'b0;
      occ_d      = 2'd0;
      case (state_d)
         EMPTY: begin
            up_ready_d = 1'b1;
            dn_valid_d = 1'b0;
            occ_d      = 2'd0;
         end
         FULL: begin
            up_ready_d = 1'b1;
            dn_valid_d = 1'b1;
            occ_d      = 2'd1;
         end
         SKID: begin
            up_ready_d = 1'b0;
            dn_valid_d = 1'b1;
            occ_d      = 2'd2;
         end
         default: begin
            up_ready_d = 1'b1;
            dn_valid_d = 1'b0;
            occ_d      = 2'd0;
         end
      endcase
   end

   // State and status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         up_ready_q <= 1'b1;
         dn_valid_q <= 1'b0;
         occ_q      <= 2'd0;
      end else begin
         state_q    <= state_d;
         up_ready_q <= up_ready_d;
         dn_valid_q <= dn_valid_d;
         occ_q      <= occ_d;
      end
   end

   assign main_ctrl_in_s = main_from_skid_s ? skid_ctrl_s : up_ctrl_i;
   assign main_data_in_s = main_from_skid_s ? skid_data_s : up_data_i;

   pipe_slot #(
      .CTRL_W (CTRL_W),
      .DATA_W (PAYLOAD_W)
   ) u_main (
      .clk        (clk),
      .rst        (rst),
      .load_i     (main_load_s),
      .clr_ctrl_i (main_clr_s),
      .ctrl_i     (main_ctrl_in_s),
      .data_i     (main_data_in_s),
      .ctrl_o     (main_ctrl_s),
      .data_o     (main_data_s)
   );

   pipe_slot #(
      .CTRL_W (CTRL_W),
      .DATA_W (PAYLOAD_W)
   ) u_skid (
      .clk        (clk),
      .rst        (rst),
      .load_i     (skid_load_s),
      .clr_ctrl_i (skid_clr_s),
      .ctrl_i     (up_ctrl_i),
      .data_i     (up_data_i),
      .ctrl_o     (skid_ctrl_s),
      .data_o     (skid_data_s)
   );

   assign up_ready_o  = up_ready_q;
   assign dn_valid_o  = dn_valid_q;
   assign dn_ctrl_o   = main_ctrl_s;
   assign dn_data_o   = main_data_s;
   assign occupancy_o = occ_q;

endmodule
